// File: rtl/candy_pkg.sv
// Shared definitions for the candy dispense command intake.
// Contents: FSM state encoding, amount codes, default timing constants,
// and a small helper that classifies an amount code.
package candy_pkg;

    // Intake FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_e;

    // Pi amount codes
    localparam logic [1:0] AMT_1   = 2'b00;
    localparam logic [1:0] AMT_2   = 2'b01;
    localparam logic [1:0] AMT_3   = 2'b10;
    localparam logic [1:0] AMT_BAD = 2'b11;

    // Default timing at 12 MHz: 1 ms debounce, 8 s dispense timeout
    localparam int DEBOUNCE_CYC_DEF = 12000;
    localparam int TIMEOUT_CYC_DEF  = 96000000;
    localparam int CNT_W_DEF        = 27;

    // Debounce counter width (holds DEBOUNCE_CYC up to 16383)
    localparam int DB_CNT_W = 14;

    // True when the amount code is the reserved value
    function automatic logic amt_is_bad(input logic [1:0] amt);
        return (amt == AMT_BAD);
    endfunction

endpackage

// File: rtl/candy_cmd_intake_if.sv
// Command bus between the intake (master) and the dispenser (slave).
// Signals:
//   cmd_valid  master->slave  command valid
//   cmd_amount master->slave  amount code, stable while cmd_valid=1
//   cmd_ready  slave->master  command accepted when cmd_valid&cmd_ready
//   disp_done  slave->master  one-cycle pulse, dispense finished
interface candy_cmd_intake_if;
    logic       cmd_valid;
    logic [1:0] cmd_amount;
    logic       cmd_ready;
    logic       disp_done;

    modport master (output cmd_valid, output cmd_amount, input cmd_ready, input disp_done);
    modport slave  (input cmd_valid, input cmd_amount, output cmd_ready, output disp_done);
endinterface

// File: rtl/gpio_debounce.sv
// Two-flop synchroniser followed by a debouncer for one asynchronous line.
// The debounced output follows the synchronised input only after the two
// have disagreed for DEBOUNCE_CYC consecutive cycles; any agreement restarts
// the count. Pin-to-output latency is DEBOUNCE_CYC+2 cycles.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   din   in  asynchronous raw line
//   dout  out debounced level
module gpio_debounce
    import candy_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [DB_CNT_W-1:0] DB_ZERO = {DB_CNT_W{1'b0}};
    localparam logic [DB_CNT_W-1:0] DB_ONE  = {{(DB_CNT_W-1){1'b0}}, 1'b1};

    logic                meta_r;
    logic                sync_r;
    logic                db_r;
    logic [DB_CNT_W-1:0] cnt_r;

    // Synchroniser chain and stability counter; >= keeps the count from wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            db_r   <= 1'b0;
            cnt_r  <= DB_ZERO;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            if (sync_r == db_r) begin
                cnt_r <= DB_ZERO;
            end else if (cnt_r >= DB_LAST) begin
                db_r  <= sync_r;
                cnt_r <= DB_ZERO;
            end else begin
                cnt_r <= cnt_r + DB_ONE;
            end
        end
    end

    assign dout = db_r;

endmodule

// File: rtl/candy_cmd_intake.sv
// Front end of the candy dispense controller.
// Debounces the Pi request lines, issues one valid/ready command per debounced
// rising edge of candyflag, waits for disp_done (or a timeout), then holds the
// handshake line to the Pi until the flag is debounced low.
// Ports:
//   clk_x1          in   12 MHz system clock
//   rst             in   synchronous active-high reset
//   candyflag_in    in   async Pi request line
//   stateamount_in  in   async Pi amount code (11 reserved)
//   cmd_bus         master modport: cmd_valid/cmd_amount out, cmd_ready/disp_done in
//   handshake       out  request serviced, held until flag debounced low
//   err_timeout     out  sticky, cleared on next accepted request
//   err_badcode     out  sticky, cleared on next accepted request
module candy_cmd_intake
    import candy_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                 clk_x1,
    input  logic                 rst,
    input  logic                 candyflag_in,
    input  logic [1:0]           stateamount_in,
    candy_cmd_intake_if.master   cmd_bus,
    output logic                 handshake,
    output logic                 err_timeout,
    output logic                 err_badcode
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    // A pin held high through reset reaches the debounced flag after
    // DEBOUNCE_CYC+2 cycles; the flag must stay low beyond that to arm.
    localparam logic [CNT_W-1:0] ARM_CYC  = CNT_W'(DEBOUNCE_CYC + 4);

    logic       flag_db_s;
    logic [1:0] amt_db_s;
    logic       flag_rise_s;

    state_e     state_r, state_nxt;
    logic [CNT_W-1:0] cnt_r, cnt_nxt;
    logic [1:0] amt_r, amt_nxt;
    logic       flag_prev_r;
    logic       armed_r, armed_nxt;
    logic       cmd_valid_r, cmd_valid_nxt;
    logic [1:0] cmd_amount_r, cmd_amount_nxt;
    logic       hs_r, hs_nxt;
    logic       err_to_r, err_to_nxt;
    logic       err_bad_r, err_bad_nxt;

    gpio_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_flag (
        .clk (clk_x1), .rst (rst), .din (candyflag_in), .dout (flag_db_s)
    );
    gpio_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_amt0 (
        .clk (clk_x1), .rst (rst), .din (stateamount_in[0]), .dout (amt_db_s[0])
    );
    gpio_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_amt1 (
        .clk (clk_x1), .rst (rst), .din (stateamount_in[1]), .dout (amt_db_s[1])
    );

    assign flag_rise_s = flag_db_s & ~flag_prev_r;

    // State, counter, capture and registered outputs
    always_ff @(posedge clk_x1) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= CNT_ZERO;
            amt_r        <= 2'b00;
            flag_prev_r  <= 1'b0;
            armed_r      <= 1'b0;
            cmd_valid_r  <= 1'b0;
            cmd_amount_r <= 2'b00;
            hs_r         <= 1'b0;
            err_to_r     <= 1'b0;
            err_bad_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt;
            cnt_r        <= cnt_nxt;
            amt_r        <= amt_nxt;
            flag_prev_r  <= flag_db_s;
            armed_r      <= armed_nxt;
            cmd_valid_r  <= cmd_valid_nxt;
            cmd_amount_r <= cmd_amount_nxt;
            hs_r         <= hs_nxt;
            err_to_r     <= err_to_nxt;
            err_bad_r    <= err_bad_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state_r;
        cnt_nxt       = cnt_r;
        amt_nxt       = amt_r;
        armed_nxt     = armed_r;
        cmd_valid_nxt = 1'b0;
        hs_nxt        = 1'b0;
        err_to_nxt    = err_to_r;
        err_bad_nxt   = err_bad_r;

        case (state_r)
            IDLE: begin
                if (!armed_r) begin
                    // Counter measures how long the flag has been low since reset
                    if (flag_db_s) begin
                        cnt_nxt = CNT_ZERO;
                    end else if (cnt_r >= ARM_CYC) begin
                        armed_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_r + CNT_ONE;
                    end
                end else if (flag_rise_s) begin
                    amt_nxt = amt_db_s;
                    if (amt_is_bad(amt_db_s)) begin
                        err_bad_nxt = 1'b1;
                        hs_nxt      = 1'b1;
                        state_nxt   = ACK;
                    end else begin
                        err_bad_nxt   = 1'b0;
                        err_to_nxt    = 1'b0;
                        cmd_valid_nxt = 1'b1;
                        state_nxt     = ISSUE;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                // Flag changes are ignored here: an issued command is never aborted
                if (cmd_valid_r && cmd_bus.cmd_ready) begin
                    cnt_nxt   = CNT_ZERO;
                    state_nxt = WAIT;
                end else begin
                    cmd_valid_nxt = 1'b1;
                end
            end
            WAIT: begin
                // disp_done is checked first so a collision with timeout is not an error
                if (cmd_bus.disp_done) begin
                    hs_nxt    = 1'b1;
                    state_nxt = ACK;
                end else if (cnt_r == TO_LAST) begin
                    err_to_nxt = 1'b1;
                    hs_nxt     = 1'b1;
                    state_nxt  = ACK;
                end else if (cnt_r != CNT_MAX) begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end else begin
                    cnt_nxt = cnt_r;
                end
            end
            ACK: begin
                if (flag_db_s) begin
                    hs_nxt = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        cmd_amount_nxt = cmd_valid_nxt ? amt_nxt : 2'b00;
    end

    assign cmd_bus.cmd_valid  = cmd_valid_r;
    assign cmd_bus.cmd_amount = cmd_amount_r;
    assign handshake          = hs_r;
    assign err_timeout        = err_to_r;
    assign err_badcode        = err_bad_r;

endmodule

// File: tb/tb_candy_cmd_intake.sv
module tb_candy_cmd_intake;

    logic       clk_x1 = 1'b0;
    logic       rst = 1'b1;
    logic       candyflag_in = 1'b0;
    logic [1:0] stateamount_in = 2'b00;
    logic       handshake;
    logic       err_timeout;
    logic       err_badcode;

    candy_cmd_intake_if bus ();

    candy_cmd_intake #(
        .DEBOUNCE_CYC (4),
        .TIMEOUT_CYC  (50),
        .CNT_W        (27)
    ) dut (
        .clk_x1         (clk_x1),
        .rst            (rst),
        .candyflag_in   (candyflag_in),
        .stateamount_in (stateamount_in),
        .cmd_bus        (bus),
        .handshake      (handshake),
        .err_timeout    (err_timeout),
        .err_badcode    (err_badcode)
    );

    always #5 clk_x1 = ~clk_x1;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference state: expected command sequence and sticky error flags
    logic [1:0] exp_q[$];
    logic [1:0] acc_q[$];
    logic       m_err_to = 1'b0;
    logic       m_err_bad = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Bus monitor: record accepted commands, flag instability under backpressure
    int         stab_err = 0;
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [1:0] pa = 2'b00;
    always @(posedge clk_x1) begin
        if (rst) begin
            pv <= 1'b0;
        end else begin
            if (bus.cmd_valid && bus.cmd_ready) acc_q.push_back(bus.cmd_amount);
            if (pv && !pr && (!bus.cmd_valid || bus.cmd_amount != pa)) stab_err <= stab_err + 1;
            pv <= bus.cmd_valid;
            pa <= bus.cmd_amount;
            pr <= bus.cmd_ready;
        end
    end

    task automatic tick();
        @(posedge clk_x1);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check_val(tag, {27'd0, bus.cmd_valid, bus.cmd_amount, handshake, err_timeout, err_badcode}, 32'd0);
    endtask

    // One Pi request. rd: cycles of backpressure; dd: cycles after acceptance
    // before disp_done, or -1 for no done (timeout).
    task automatic do_request(input logic [1:0] amt, input int rd, input bit glitch, input int dd);
        int lat;
        int vcnt;
        stateamount_in = amt;
        tick(); tick();
        candyflag_in = 1'b1;
        lat = 0;
        if (amt == 2'b11) begin
            vcnt = 0;
            while (!handshake && lat < 20) begin
                tick(); lat++;
                if (bus.cmd_valid) vcnt++;
            end
            m_err_bad = 1'b1;
            check_val("bad_no_cmd", vcnt, 0);
            check_val("bad_hs", {31'd0, handshake}, 1);
            check_val("bad_err", {30'd0, err_timeout, err_badcode}, {30'd0, m_err_to, m_err_bad});
        end else begin
            while (!bus.cmd_valid && lat < 20) begin
                tick(); lat++;
            end
            check_val("cmd_lat_6_7", ((lat >= 6) && (lat <= 7)) ? 1 : 0, 1);
            check_val("cmd_amount", {30'd0, bus.cmd_amount}, {30'd0, amt});
            m_err_to = 1'b0;
            m_err_bad = 1'b0;
            check_val("err_cleared", {30'd0, err_timeout, err_badcode}, 0);
            vcnt = 1;
            for (int i = 0; i < rd; i++) begin
                if (glitch && i == 0) candyflag_in = 1'b0;
                if (glitch && i == 2) candyflag_in = 1'b1;
                tick();
                if (bus.cmd_valid && bus.cmd_amount == amt) vcnt++;
            end
            candyflag_in = 1'b1;
            bus.cmd_ready = 1'b1;
            tick();
            bus.cmd_ready = 1'b0;
            exp_q.push_back(amt);
            check_val("valid_cycles", vcnt, rd + 1);
            check_val("valid_drop", {31'd0, bus.cmd_valid}, 0);
            if (dd < 0) begin
                lat = 0;
                while (!handshake && lat < 60) begin
                    tick(); lat++;
                end
                m_err_to = 1'b1;
                check_val("timeout_lat", lat, 50);
                check_val("timeout_err", {31'd0, err_timeout}, 1);
            end else begin
                for (int i = 0; i < dd; i++) tick();
                check_val("hs_before_done", {31'd0, handshake}, 0);
                bus.disp_done = 1'b1;
                tick();
                bus.disp_done = 1'b0;
                check_val("done_hs", {31'd0, handshake}, 1);
                check_val("done_no_err", {31'd0, err_timeout}, {31'd0, m_err_to});
            end
        end
        candyflag_in = 1'b0;
        lat = 0;
        while (handshake && lat < 10) begin
            tick(); lat++;
        end
        check_val("hs_release", (!handshake && lat <= 7) ? 1 : 0, 1);
        check_val("err_hold", {30'd0, err_timeout, err_badcode}, {30'd0, m_err_to, m_err_bad});
        repeat (4) tick();
    endtask

    // Short flag pulse while idle must not start a request
    task automatic idle_glitch();
        int act;
        candyflag_in = 1'b1;
        tick(); tick();
        candyflag_in = 1'b0;
        act = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.cmd_valid || handshake) act++;
        end
        check_val("idle_glitch", act, 0);
    endtask

    initial begin
        int act;
        bus.cmd_ready = 1'b0;
        bus.disp_done = 1'b0;

        // Reset with flag low
        rst = 1'b1;
        repeat (3) tick();
        check_zero("reset_outputs");
        rst = 1'b0;
        act = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.cmd_valid) act++;
        end
        check_val("no_cmd_after_reset", act, 0);
        check_zero("idle_outputs");

        // Directed: normal, backpressure+glitch, bad code, timeout, collision
        do_request(2'b01, 0, 1'b0, 10);
        do_request(2'b10, 15, 1'b1, 3);
        do_request(2'b11, 0, 1'b0, 0);
        do_request(2'b00, 2, 1'b0, -1);
        do_request(2'b11, 0, 1'b0, 0);
        do_request(2'b01, 0, 1'b0, 49);
        idle_glitch();

        // Reset while waiting for disp_done, flag held high through reset
        stateamount_in = 2'b10;
        tick(); tick();
        candyflag_in = 1'b1;
        act = 0;
        while (!bus.cmd_valid && act < 20) begin
            tick(); act++;
        end
        bus.cmd_ready = 1'b1;
        tick();
        bus.cmd_ready = 1'b0;
        exp_q.push_back(2'b10);
        repeat (5) tick();
        rst = 1'b1;
        tick(); tick();
        check_zero("midop_reset_outputs");
        rst = 1'b0;
        m_err_to = 1'b0;
        m_err_bad = 1'b0;
        act = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.cmd_valid || handshake) act++;
        end
        check_val("flag_high_from_reset", act, 0);
        candyflag_in = 1'b0;
        repeat (15) tick();

        // Back-to-back sequence
        do_request(2'b00, 0, 1'b0, 5);
        do_request(2'b01, 0, 1'b0, 5);
        do_request(2'b10, 0, 1'b0, 5);

        // Randomised requests
        for (int n = 0; n < 10; n++) begin
            logic [1:0] a;
            int rd;
            bit g;
            int dd;
            a  = 2'($urandom_range(0, 3));
            rd = int'($urandom_range(0, 15));
            g  = (rd >= 3) && ($urandom_range(0, 1) == 1);
            dd = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 49));
            if ($urandom_range(0, 2) == 0) idle_glitch();
            do_request(a, rd, g, dd);
        end

        repeat (5) tick();
        check_val("cmd_count", acc_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
            check_val($sformatf("cmd_seq_%0d", i), {30'd0, acc_q[i]}, {30'd0, exp_q[i]});
        end
        check_val("hold_stable", stab_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
